// File: rtl/seg7_pkg.sv
// seg7_pkg: shared constants for the seven-segment IO controller.
// IO register select codes, the active-low hex segment table and
// reset values for the mask registers.
package seg7_pkg;

    typedef enum logic [1:0] {
        SEL_VAL_LO  = 2'd0,
        SEL_VAL_HI  = 2'd1,
        SEL_DP_MASK = 2'd2,
        SEL_EN_MASK = 2'd3
    } io_sel_e;

    // Active-low {dp,g,f,e,d,c,b,a} patterns for hex digits 0..F, dp off.
    localparam logic [7:0] SEG_CODES [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };

    localparam logic [7:0] EN_MASK_RST = 8'hFF;
    localparam logic [7:0] DP_MASK_RST = 8'h00;

endpackage

// File: rtl/seg7_io_ctrl_if.sv
// seg7_io_ctrl_if: CPU IO register port of the seven-segment controller.
// master = CPU side, slave = controller side.
interface seg7_io_ctrl_if;

    logic        io_we;
    logic [1:0]  io_sel;
    logic [23:0] io_wdata;
    logic [23:0] io_rdata;

    modport master (output io_we, output io_sel, output io_wdata, input io_rdata);
    modport slave  (input io_we, input io_sel, input io_wdata, output io_rdata);

endinterface

// File: rtl/seg7_decode.sv
// seg7_decode: nibble + decimal point to active-low segment pattern.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       dp,
    output logic [7:0] seg_n
);

    // Table lookup, then pull the dp segment low when requested.
    always_comb begin
        seg_n = SEG_CODES[nibble];
        if (dp) seg_n[7] = 1'b0;
    end

endmodule

// File: rtl/seg7_io_ctrl.sv
// seg7_io_ctrl: memory-mapped 8-digit multiplexed seven-segment driver.
// Optional feature macro: LEADING_ZERO_BLANK_EN (blank leading zero digits).
module seg7_io_ctrl
    import seg7_pkg::*;
#(
    parameter int unsigned SCAN_DIV   = 50000,
    parameter int unsigned NUM_DIGITS = 8
) (
    input  logic                 clock,
    input  logic                 reset,
    seg7_io_ctrl_if.slave        io,
    output logic [7:0]           seg_n,
    output logic [7:0]           an_n
);

    localparam int unsigned CNT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IDX_W = $clog2(NUM_DIGITS);

    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_nx;
    logic             wrap;
    logic [31:0]      value;
    logic [7:0]       dp_mask;
    logic [7:0]       en_mask;
    logic [3:0]       nibble;
    logic [7:0]       dec_seg;
    logic             digit_on;
    logic [7:0]       seg_d;
    logic [7:0]       an_d;

    // Output is built from the post-wrap digit index so a wrap shows on the
    // very next output, while register writes show one edge later.
    always_comb begin
        wrap   = (cnt == CNT_W'(SCAN_DIV - 1));
        idx_nx = wrap ? idx + IDX_W'(1) : idx;
        nibble = value[{idx_nx, 2'b00} +: 4];
    end

    seg7_decode u_decode (
        .nibble (nibble),
        .dp     (dp_mask[idx_nx]),
        .seg_n  (dec_seg)
    );

`ifdef LEADING_ZERO_BLANK_EN
    logic [IDX_W-1:0] msn;

    // Locate the most-significant non-zero nibble; digit 0 when value is 0.
    always_comb begin
        msn = '0;
        for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
            if (value[4*i +: 4] != 4'h0) msn = IDX_W'(i);
        end
        digit_on = en_mask[idx_nx] && !((idx_nx > msn) && !dp_mask[idx_nx]);
    end
`else
    // Every enabled digit is shown, leading zeros included.
    always_comb begin
        digit_on = en_mask[idx_nx];
    end
`endif

    // Next segment/anode pattern for the selected digit.
    always_comb begin
        seg_d = digit_on ? dec_seg : 8'hFF;
        an_d  = '1;
        an_d[idx_nx] = ~digit_on;
    end

    // Combinational register readback, zero-extended.
    always_comb begin
        io.io_rdata = '0;
        case (io.io_sel)
            SEL_VAL_LO:  io.io_rdata = value[23:0];
            SEL_VAL_HI:  io.io_rdata[7:0] = value[31:24];
            SEL_DP_MASK: io.io_rdata[7:0] = dp_mask;
            SEL_EN_MASK: io.io_rdata[7:0] = en_mask;
            default:     io.io_rdata = '0;
        endcase
    end

    // Register writes, scan prescaler/index and registered display outputs.
    always_ff @(posedge clock) begin
        if (reset) begin
            value   <= '0;
            dp_mask <= DP_MASK_RST;
            en_mask <= EN_MASK_RST;
            cnt     <= '0;
            idx     <= '0;
            seg_n   <= '1;
            an_n    <= '1;
        end else begin
            if (io.io_we) begin
                case (io.io_sel)
                    SEL_VAL_LO:  value[23:0]  <= io.io_wdata;
                    SEL_VAL_HI:  value[31:24] <= io.io_wdata[7:0];
                    SEL_DP_MASK: dp_mask      <= io.io_wdata[7:0];
                    SEL_EN_MASK: en_mask      <= io.io_wdata[7:0];
                    default:     ;
                endcase
            end
            cnt   <= wrap ? '0 : cnt + CNT_W'(1);
            idx   <= idx_nx;
            seg_n <= seg_d;
            an_n  <= an_d;
        end
    end

endmodule

// File: tb/tb_seg7_io_ctrl.sv
// tb_seg7_io_ctrl: directed self-checking bench for seg7_io_ctrl, SCAN_DIV=4.
// Edge Ek means the k-th rising edge after reset is released.
module tb_seg7_io_ctrl;

`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] seg_n;
    logic [7:0] an_n;
    int         errors = 0;
    int         checks = 0;

    seg7_io_ctrl_if bus ();

    seg7_io_ctrl #(.SCAN_DIV(4), .NUM_DIGITS(8)) dut (
        .clock (clk),
        .reset (reset),
        .io    (bus),
        .seg_n (seg_n),
        .an_n  (an_n)
    );

    always #5 clk = ~clk;

    // Advance n rising edges, then settle 1 time unit past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.io_we = 1'b0;
        step(2);
        reset = 1'b0;
    endtask

    task automatic wr(input logic [1:0] sel, input logic [23:0] data);
        bus.io_we = 1'b1;
        bus.io_sel = sel;
        bus.io_wdata = data;
        step(1);
        bus.io_we = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        bus.io_we = 1'b1;
        bus.io_sel = 2'd3;
        bus.io_wdata = 24'h000000;
        step(2);
        checks++; if (seg_n !== 8'hFF) begin errors++; $display("FAIL rst_seg got=%h exp=FF", seg_n); end
        checks++; if (an_n !== 8'hFF) begin errors++; $display("FAIL rst_an got=%h exp=FF", an_n); end
        checks++; if (bus.io_rdata !== 24'h0000FF) begin errors++; $display("FAIL rst_en_over_we got=%h exp=0000FF", bus.io_rdata); end
        bus.io_we = 1'b0;
        bus.io_sel = 2'd0;
        #1;
        checks++; if (bus.io_rdata !== 24'h000000) begin errors++; $display("FAIL rst_val got=%h exp=000000", bus.io_rdata); end
        reset = 1'b0;
        step(1);
        checks++; if (an_n !== 8'hFE || seg_n !== 8'hC0) begin errors++; $display("FAIL rel_first got=%h/%h exp=FE/C0", an_n, seg_n); end
        step(3);
        checks++; if (an_n !== (LZB ? 8'hFF : 8'hFD) || seg_n !== (LZB ? 8'hFF : 8'hC0)) begin errors++; $display("FAIL scan_d1 got=%h/%h", an_n, seg_n); end
        step(27);
        checks++; if (an_n !== (LZB ? 8'hFF : 8'h7F) || seg_n !== (LZB ? 8'hFF : 8'hC0)) begin errors++; $display("FAIL scan_d7 got=%h/%h", an_n, seg_n); end
        step(1);
        checks++; if (an_n !== 8'hFE || seg_n !== 8'hC0) begin errors++; $display("FAIL scan_wrap0 got=%h/%h exp=FE/C0", an_n, seg_n); end
    endtask

    task automatic test_value();
        do_reset();
        wr(2'd0, 24'h543210);   // E1
        wr(2'd1, 24'h000076);   // E2
        bus.io_sel = 2'd1;
        #1;
        checks++; if (bus.io_rdata !== 24'h000076) begin errors++; $display("FAIL rd_hi got=%h exp=000076", bus.io_rdata); end
        bus.io_sel = 2'd0;
        #1;
        checks++; if (bus.io_rdata !== 24'h543210) begin errors++; $display("FAIL rd_lo got=%h exp=543210", bus.io_rdata); end
        step(2);                // E4
        checks++; if (an_n !== 8'hFD || seg_n !== 8'hF9) begin errors++; $display("FAIL val_d1 got=%h/%h exp=FD/F9", an_n, seg_n); end
        step(4);                // E8
        checks++; if (an_n !== 8'hFB || seg_n !== 8'hA4) begin errors++; $display("FAIL val_d2 got=%h/%h exp=FB/A4", an_n, seg_n); end
        step(20);               // E28
        checks++; if (an_n !== 8'h7F || seg_n !== 8'hF8) begin errors++; $display("FAIL val_d7 got=%h/%h exp=7F/F8", an_n, seg_n); end
    endtask

    task automatic test_masks();
        do_reset();
        wr(2'd2, 24'h000001);   // E1: output still from old dp_mask
        checks++; if (seg_n !== 8'hC0) begin errors++; $display("FAIL dp_latency got=%h exp=C0", seg_n); end
        wr(2'd3, 24'h0000FE);   // E2: dp visible, en write pending
        checks++; if (an_n !== 8'hFE || seg_n !== 8'h40) begin errors++; $display("FAIL dp_on got=%h/%h exp=FE/40", an_n, seg_n); end
        step(1);                // E3
        checks++; if (an_n !== 8'hFF || seg_n !== 8'hFF) begin errors++; $display("FAIL en_off got=%h/%h exp=FF/FF", an_n, seg_n); end
        step(1);                // E4: digit 1 enabled, no dp
        checks++; if (an_n !== (LZB ? 8'hFF : 8'hFD) || seg_n !== (LZB ? 8'hFF : 8'hC0)) begin errors++; $display("FAIL en_d1 got=%h/%h", an_n, seg_n); end
        bus.io_sel = 2'd2;
        #1;
        checks++; if (bus.io_rdata !== 24'h000001) begin errors++; $display("FAIL rd_dp got=%h exp=000001", bus.io_rdata); end
        bus.io_sel = 2'd3;
        #1;
        checks++; if (bus.io_rdata !== 24'h0000FE) begin errors++; $display("FAIL rd_en got=%h exp=0000FE", bus.io_rdata); end
    endtask

    task automatic test_wrap_write();
        do_reset();
        step(3);                // E3
        wr(2'd0, 24'h000010);   // E4: write coincides with wrap
        checks++; if (an_n !== (LZB ? 8'hFF : 8'hFD) || seg_n !== (LZB ? 8'hFF : 8'hC0)) begin errors++; $display("FAIL wrap_old got=%h/%h", an_n, seg_n); end
        step(1);                // E5
        checks++; if (an_n !== 8'hFD || seg_n !== 8'hF9) begin errors++; $display("FAIL wrap_new got=%h/%h exp=FD/F9", an_n, seg_n); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        wr(2'd2, 24'h000000);   // E1
        wr(2'd3, 24'h0000FF);   // E2
        wr(2'd1, 24'h000000);   // E3
        wr(2'd2, 24'h000000);   // E4: writes every cycle, scan keeps going
        checks++; if (an_n !== (LZB ? 8'hFF : 8'hFD)) begin errors++; $display("FAIL b2b_scan got=%h", an_n); end
    endtask

    task automatic test_mid_reset();
        do_reset();
        wr(2'd0, 24'h123456);   // E1
        wr(2'd2, 24'h0000AA);   // E2
        wr(2'd3, 24'h0000F0);   // E3
        step(18);               // E21: digit 5 = 1 with dp
        checks++; if (an_n !== 8'hDF || seg_n !== 8'h79) begin errors++; $display("FAIL mid_d5 got=%h/%h exp=DF/79", an_n, seg_n); end
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        checks++; if (an_n !== 8'hFF || seg_n !== 8'hFF) begin errors++; $display("FAIL mid_rst_out got=%h/%h exp=FF/FF", an_n, seg_n); end
        bus.io_sel = 2'd0; #1;
        checks++; if (bus.io_rdata !== 24'h000000) begin errors++; $display("FAIL mid_rd_val got=%h exp=000000", bus.io_rdata); end
        bus.io_sel = 2'd2; #1;
        checks++; if (bus.io_rdata !== 24'h000000) begin errors++; $display("FAIL mid_rd_dp got=%h exp=000000", bus.io_rdata); end
        bus.io_sel = 2'd3; #1;
        checks++; if (bus.io_rdata !== 24'h0000FF) begin errors++; $display("FAIL mid_rd_en got=%h exp=0000FF", bus.io_rdata); end
        step(3);                // release +3: still digit 0
        checks++; if (an_n !== 8'hFE || seg_n !== 8'hC0) begin errors++; $display("FAIL mid_dwell got=%h/%h exp=FE/C0", an_n, seg_n); end
        step(1);
        checks++; if (an_n !== (LZB ? 8'hFF : 8'hFD)) begin errors++; $display("FAIL mid_adv got=%h", an_n); end
    endtask

    task automatic test_lzb();
        do_reset();
        wr(2'd0, 24'h000A00);   // E1
        step(3);                // E4: digit 1 is an inner zero
        checks++; if (an_n !== 8'hFD || seg_n !== 8'hC0) begin errors++; $display("FAIL lzb_d1 got=%h/%h exp=FD/C0", an_n, seg_n); end
        step(4);                // E8
        checks++; if (an_n !== 8'hFB || seg_n !== 8'h88) begin errors++; $display("FAIL lzb_d2 got=%h/%h exp=FB/88", an_n, seg_n); end
        step(4);                // E12
        checks++; if (an_n !== 8'hFF || seg_n !== 8'hFF) begin errors++; $display("FAIL lzb_d3 got=%h/%h exp=FF/FF", an_n, seg_n); end
        step(16);               // E28
        checks++; if (an_n !== 8'hFF || seg_n !== 8'hFF) begin errors++; $display("FAIL lzb_d7 got=%h/%h exp=FF/FF", an_n, seg_n); end
        step(4);                // E32
        checks++; if (an_n !== 8'hFE || seg_n !== 8'hC0) begin errors++; $display("FAIL lzb_d0 got=%h/%h exp=FE/C0", an_n, seg_n); end
    endtask

    initial begin
        reset = 1'b1;
        bus.io_we = 1'b0;
        bus.io_sel = 2'd0;
        bus.io_wdata = '0;
        test_reset();
        test_value();
        test_masks();
        test_wrap_write();
        test_back_to_back();
        test_mid_reset();
        if (LZB) test_lzb();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/seg7_io_ctrl.md
SEG7_IO_CTRL -- requirements
Module: seg7_io_ctrl

Interface
REQ-001 Parameter SCAN_DIV, default 50000; clock cycles each digit stays lit (legal range 2..2^20).
REQ-002 Parameter NUM_DIGITS, default 8; fixed at 8 in this revision, other values are illegal.
REQ-003 clock  in  1  CPU clock (clk_out1 domain); the single clock of the block.
REQ-004 reset  in  1  synchronous, active-high reset, sampled on rising edge of clock.
REQ-005 io_we  in  1  CPU IO write strobe, one cycle per store.
REQ-006 io_sel  in  2  register select: 0=VAL_LO, 1=VAL_HI, 2=DP_MASK, 3=EN_MASK.
REQ-007 io_wdata  in  24  CPU IO store data.
REQ-008 io_rdata  out  24  readback of the register selected by io_sel, zero-extended.
REQ-009 seg_n  out  8  active-low segments {dp,g,f,e,d,c,b,a}.
REQ-010 an_n  out  8  active-low digit enables; bit i drives digit i.

Function
REQ-011 Writes: on a clock edge with io_we=1:
- sel0 loads value[23:0] from io_wdata[23:0].
- sel1 loads value[31:24] from io_wdata[7:0].
- sel2 loads dp_mask from io_wdata[7:0].
- sel3 loads en_mask from io_wdata[7:0].
REQ-012 io_rdata is combinational from io_sel: sel0 value[23:0], sel1 value[31:24], sel2 dp_mask, sel3 en_mask; unused bits 0.
REQ-013 Prescaler counts 0..SCAN_DIV-1 and wraps to 0. Each wrap advances digit index idx by 1 modulo 8 (7 -> 0).
REQ-014 seg_n and an_n are registered and recomputed every cycle from the current idx, value, dp_mask and en_mask.
- Latency from a register write to the visible output is 2 clock edges.
REQ-015 Digit idx displays nibble value[4*idx+3:4*idx].
- Active-low codes 0-F: C0 F9 A4 B0 99 92 82 F8 80 90 88 83 C6 A1 86 8E (hex).
- dp_mask[idx]=1 clears seg_n[7].
REQ-016 an_n = all ones except bit idx, which is 0 only if en_mask[idx]=1; a digit disabled by en_mask also drives seg_n=8'hFF.
REQ-017 Write and prescaler wrap in the same cycle both take effect; the output of the following cycle uses the new idx and the pre-write register values.
REQ-018 io_we with any io_sel never stalls or resets the scan.

Reset
REQ-019 While reset=1: value=0, dp_mask=0, en_mask=8'hFF, prescaler=0, idx=0, seg_n=8'hFF, an_n=8'hFF.
REQ-020 Reset overrides a simultaneous io_we.
REQ-021 Reset asserted mid-scan returns to idx 0 with a full SCAN_DIV dwell.
REQ-022 First cycle after reset release: an_n=8'hFE, seg_n=8'hC0.

Configuration
REQ-023 With LEADING_ZERO_BLANK_EN defined:
- Digits above the most-significant non-zero nibble of value are blanked (seg_n=8'hFF, an_n bit high), unless that digit's dp_mask bit is 1.
- Digit 0 is never blanked by this rule.
REQ-024 Without LEADING_ZERO_BLANK_EN, all digits with en_mask set display their nibble, including leading zeros.

Structure
REQ-025 Package seg7_pkg holds the io_sel codes, the 16-entry segment code table, and reset constants for en_mask/dp_mask.
REQ-026 Sub-module seg7_decode (4-bit nibble + dp -> 8-bit active-low segments, combinational) is instantiated once and fed by the idx nibble mux.

Verification (SCAN_DIV=4)
REQ-027 Reset, then release -> an_n=FE, seg_n=C0; after 4 cycles an_n=FD; after 32 cycles idx is back at 0 (an_n=FE).
REQ-028 io_we sel0 data 0x543210 and sel1 data 0x76 -> idx 1 shows seg_n=F9, idx 7 shows F8; io_rdata with sel1 = 0x000076.
REQ-029 Write sel2=0x01 -> two edges later at idx 0 seg_n=0x40; write sel3=0xFE -> at idx 0 an_n=FF and seg_n=FF.
REQ-030 Write sel0 in the cycle the prescaler wraps -> the next output uses the new idx with the old value, and the cycle after uses the new value.
REQ-031 Assert reset for 1 cycle at idx 5 -> all registers return to reset values (REQ-019); read back sel3 = 0xFF.
REQ-032 LEADING_ZERO_BLANK_EN defined, value=0x00000A00 -> digits 3..7 blank, digit 2 shows 88, digits 1 and 0 show C0; value=0 -> only digit 0 lit.
